// File: rtl/if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_id_queue
// Description : Fetch-to-decode instruction FIFO that absorbs decode stalls,
//               back-pressures fetch when full and presents NOP when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_WORD = 32'h7800_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  output logic        fetch_stall,
  input  logic        dec_stall,
  input  logic        flush,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [15:0] bubble_cnt
);

  localparam int c_cnt_w = $clog2(DEPTH + 1);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

  logic [31:0]        r_mem_instr [DEPTH];
  logic [31:0]        r_mem_pc    [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [15:0]        r_bubble_cnt;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_bubble;

  assign w_full   = (r_count == c_full_cnt);
  assign w_empty  = (r_count == '0);
  assign w_push   = fetch_valid && !w_full && !flush;
  assign w_pop    = dec_valid && !dec_stall && !flush;
  assign w_bubble = w_empty && !dec_stall && !flush;

  // fetch_stall depends on the registered count only, never on dec_stall/flush
  assign fetch_stall = w_full;

  assign dec_valid  = !w_empty && !flush;
  assign dec_instr  = dec_valid ? r_mem_instr[r_rd_ptr] : NOP_WORD;
  assign dec_pc     = dec_valid ? r_mem_pc[r_rd_ptr]    : 32'h0;
  assign bubble_cnt = r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap explicitly so non-power-of-two depths work
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
      end
      r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  // Storage is never cleared; validity is tracked by the count alone
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_instr[r_wr_ptr] <= fetch_instr;
      r_mem_pc[r_wr_ptr]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_queue
// Description : Directed self-checking bench for if_id_queue (DEPTH 2 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        dec_stall;
  logic        flush;

  logic        fetch_stall2, dec_valid2;
  logic [31:0] dec_instr2, dec_pc2;
  logic [15:0] bubble_cnt2;
  logic        fetch_stall3, dec_valid3;
  logic [31:0] dec_instr3, dec_pc3;
  logic [15:0] bubble_cnt3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(2)) dut2 (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_stall(fetch_stall2), .dec_stall(dec_stall), .flush(flush),
    .dec_valid(dec_valid2), .dec_instr(dec_instr2), .dec_pc(dec_pc2),
    .bubble_cnt(bubble_cnt2)
  );

  if_id_queue #(.DEPTH(3)) dut3 (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fetch_stall(fetch_stall3), .dec_stall(dec_stall), .flush(flush),
    .dec_valid(dec_valid3), .dec_instr(dec_instr3), .dec_pc(dec_pc3),
    .bubble_cnt(bubble_cnt3)
  );

  task automatic drive(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                       input logic stall, input logic fl);
    fetch_valid = fv;
    fetch_instr = instr;
    fetch_pc    = pc;
    dec_stall   = stall;
    flush       = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    n_cmp++; if (dec_valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid2); end
    n_cmp++; if (dec_instr2 !== 32'h7800_0000) begin n_fail++; $display("FAIL reset_dec_instr: got %h want 78000000", dec_instr2); end
    n_cmp++; if (dec_pc2 !== 32'h0) begin n_fail++; $display("FAIL reset_dec_pc: got %h want 0", dec_pc2); end
    n_cmp++; if (fetch_stall2 !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_stall: got %b want 0", fetch_stall2); end
    n_cmp++; if (bubble_cnt2 !== 16'd0) begin n_fail++; $display("FAIL reset_bubble: got %0d want 0", bubble_cnt2); end
    repeat (5) tick();
    n_cmp++; if (bubble_cnt2 !== 16'd5) begin n_fail++; $display("FAIL idle_bubble: got %0d want 5", bubble_cnt2); end
    n_cmp++; if (dec_instr2 !== 32'h7800_0000) begin n_fail++; $display("FAIL idle_dec_instr: got %h want 78000000", dec_instr2); end
    n_cmp++; if (dec_valid2 !== 1'b0) begin n_fail++; $display("FAIL idle_dec_valid: got %b want 0", dec_valid2); end
  endtask

  task automatic test_streaming();
    drive(1'b1, 32'h0000_0A01, 32'h0600_2000, 1'b0, 1'b0);
    n_cmp++; if (dec_valid2 !== 1'b0) begin n_fail++; $display("FAIL stream_no_bypass: got %b want 0", dec_valid2); end
    tick();
    drive(1'b1, 32'h0000_0A02, 32'h0600_2004, 1'b0, 1'b0);
    n_cmp++; if (dec_pc2 !== 32'h0600_2000) begin n_fail++; $display("FAIL stream_pc0: got %h want 06002000", dec_pc2); end
    n_cmp++; if (fetch_stall2 !== 1'b0) begin n_fail++; $display("FAIL stream_stall0: got %b want 0", fetch_stall2); end
    tick();
    drive(1'b1, 32'h0000_0A03, 32'h0600_2008, 1'b0, 1'b0);
    n_cmp++; if (dec_pc2 !== 32'h0600_2004) begin n_fail++; $display("FAIL stream_pc1: got %h want 06002004", dec_pc2); end
    n_cmp++; if (dec_instr2 !== 32'h0000_0A02) begin n_fail++; $display("FAIL stream_instr1: got %h want 00000a02", dec_instr2); end
    n_cmp++; if (fetch_stall2 !== 1'b0) begin n_fail++; $display("FAIL stream_stall1: got %b want 0", fetch_stall2); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (dec_pc2 !== 32'h0600_2008) begin n_fail++; $display("FAIL stream_pc2: got %h want 06002008", dec_pc2); end
    tick();
    // one pop per push means the queue is empty again right after the last word
    n_cmp++; if (dec_valid2 !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b want 0", dec_valid2); end
  endtask

  task automatic test_back_pressure();
    drive(1'b1, 32'h1111_1111, 32'h0000_0100, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h2222_2222, 32'h0000_0104, 1'b1, 1'b0);
    n_cmp++; if (dec_instr2 !== 32'h1111_1111) begin n_fail++; $display("FAIL fill_head_a: got %h want 11111111", dec_instr2); end
    n_cmp++; if (fetch_stall2 !== 1'b0) begin n_fail++; $display("FAIL fill_stall_one: got %b want 0", fetch_stall2); end
    tick();
    drive(1'b1, 32'h3333_3333, 32'h0000_0108, 1'b1, 1'b0);
    n_cmp++; if (fetch_stall2 !== 1'b1) begin n_fail++; $display("FAIL fill_stall_full: got %b want 1", fetch_stall2); end
    tick();
    drive(1'b1, 32'h3333_3333, 32'h0000_0108, 1'b0, 1'b0);
    n_cmp++; if (fetch_stall2 !== 1'b1) begin n_fail++; $display("FAIL full_hold_stall: got %b want 1", fetch_stall2); end
    n_cmp++; if (dec_instr2 !== 32'h1111_1111) begin n_fail++; $display("FAIL drain_a: got %h want 11111111", dec_instr2); end
    tick();
    drive(1'b1, 32'h3333_3333, 32'h0000_0108, 1'b0, 1'b0);
    n_cmp++; if (fetch_stall2 !== 1'b0) begin n_fail++; $display("FAIL unfull_stall: got %b want 0", fetch_stall2); end
    n_cmp++; if (dec_instr2 !== 32'h2222_2222) begin n_fail++; $display("FAIL drain_b: got %h want 22222222", dec_instr2); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (dec_instr2 !== 32'h3333_3333) begin n_fail++; $display("FAIL drain_c: got %h want 33333333", dec_instr2); end
    n_cmp++; if (dec_pc2 !== 32'h0000_0108) begin n_fail++; $display("FAIL drain_c_pc: got %h want 00000108", dec_pc2); end
    tick();
    n_cmp++; if (dec_valid2 !== 1'b0) begin n_fail++; $display("FAIL drain_no_dup: got %b want 0", dec_valid2); end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'hDDDD_0001, 32'h0000_0200, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hEEEE_0002, 32'h0000_0204, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hFFFF_0003, 32'h0000_0208, 1'b1, 1'b1);
    n_cmp++; if (dec_valid2 !== 1'b0) begin n_fail++; $display("FAIL flush_dec_valid: got %b want 0", dec_valid2); end
    n_cmp++; if (dec_instr2 !== 32'h7800_0000) begin n_fail++; $display("FAIL flush_dec_instr: got %h want 78000000", dec_instr2); end
    n_cmp++; if (dec_pc2 !== 32'h0) begin n_fail++; $display("FAIL flush_dec_pc: got %h want 0", dec_pc2); end
    n_cmp++; if (fetch_stall2 !== 1'b1) begin n_fail++; $display("FAIL flush_stall_registered: got %b want 1", fetch_stall2); end
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    n_cmp++; if (fetch_stall2 !== 1'b0) begin n_fail++; $display("FAIL post_flush_stall: got %b want 0", fetch_stall2); end
    n_cmp++; if (dec_valid2 !== 1'b0) begin n_fail++; $display("FAIL post_flush_empty: got %b want 0", dec_valid2); end
    tick();
    n_cmp++; if (dec_valid2 !== 1'b0) begin n_fail++; $display("FAIL flush_word_dropped: got %b want 0", dec_valid2); end
  endtask

  task automatic test_reset_midstream();
    drive(1'b1, 32'h5555_0001, 32'h0000_0300, 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'h5555_0002, 32'h0000_0304, 1'b0, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    n_cmp++; if (dec_valid2 !== 1'b0) begin n_fail++; $display("FAIL midrst_dec_valid: got %b want 0", dec_valid2); end
    n_cmp++; if (dec_instr2 !== 32'h7800_0000) begin n_fail++; $display("FAIL midrst_dec_instr: got %h want 78000000", dec_instr2); end
    n_cmp++; if (dec_pc2 !== 32'h0) begin n_fail++; $display("FAIL midrst_dec_pc: got %h want 0", dec_pc2); end
    n_cmp++; if (fetch_stall2 !== 1'b0) begin n_fail++; $display("FAIL midrst_fetch_stall: got %b want 0", fetch_stall2); end
    n_cmp++; if (bubble_cnt2 !== 16'd0) begin n_fail++; $display("FAIL midrst_bubble: got %0d want 0", bubble_cnt2); end
    n_cmp++; if (bubble_cnt3 !== 16'd0) begin n_fail++; $display("FAIL midrst_bubble3: got %0d want 0", bubble_cnt3); end
  endtask

  // DEPTH=3 instance: fetch re-presents while stalled, decode stalls 2 of every 4 cycles
  task automatic test_wrap();
    int cnt   = 0;
    int in_i  = 0;
    int out_i = 0;
    logic push_m, pop_m;
    for (int cyc = 0; cyc < 80 && out_i < 10; cyc++) begin
      drive(in_i < 10, 32'hA000_0000 + 32'(in_i), 32'h0000_3000 + 32'(4 * in_i),
            ((cyc / 2) % 2) == 1, 1'b0);
      n_cmp++; if (fetch_stall3 !== (cnt == 3)) begin n_fail++; $display("FAIL wrap_fetch_stall cyc%0d: got %b want %b", cyc, fetch_stall3, cnt == 3); end
      n_cmp++; if (dec_valid3 !== (cnt > 0)) begin n_fail++; $display("FAIL wrap_dec_valid cyc%0d: got %b want %b", cyc, dec_valid3, cnt > 0); end
      if (cnt > 0 && !dec_stall) begin
        n_cmp++; if (dec_pc3 !== 32'h0000_3000 + 32'(4 * out_i)) begin n_fail++; $display("FAIL wrap_order %0d: got %h want %h", out_i, dec_pc3, 32'h0000_3000 + 32'(4 * out_i)); end
        n_cmp++; if (dec_instr3 !== 32'hA000_0000 + 32'(out_i)) begin n_fail++; $display("FAIL wrap_instr %0d: got %h want %h", out_i, dec_instr3, 32'hA000_0000 + 32'(out_i)); end
        out_i++;
      end
      push_m = fetch_valid && (cnt < 3);
      pop_m  = (cnt > 0) && !dec_stall;
      cnt    = cnt + int'(push_m) - int'(pop_m);
      if (push_m) in_i++;
      tick();
    end
    n_cmp++; if (out_i !== 10) begin n_fail++; $display("FAIL wrap_all_delivered: got %0d want 10", out_i); end
  endtask

  initial begin
    rst = 1'b0;
    fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
    dec_stall = 1'b0; flush = 1'b0;
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_reset_midstream();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and decode. It captures each completed fetch (instruction word plus its PC) into a small FIFO and presents the oldest entry to decode. It absorbs decode-side stalls without dropping fetched words and back-pressures fetch when full. On a branch flush it discards wrong-path entries and presents NOP to decode.

## Interface
Parameters:
- DEPTH, 2, number of queue entries; legal range 2..8, need not be a power of two.
- NOP_WORD, 32'h7800_0000, word presented when no valid instruction exists (opcode 5'b01111, remaining bits zero).

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  reset, synchronous, active-high; sampled on posedge clk.
- fetch_valid  in  1  fetch has a completed instruction this cycle (memory Done).
- fetch_instr  in  32  instruction word from fetch.
- fetch_pc  in  32  PC of fetch_instr.
- fetch_stall  out  1  queue full; fetch must hold its PC and re-present the same word.
- dec_stall  in  1  decode cannot consume this cycle (hazard unit).
- flush  in  1  branch resolved taken; discard all entries.
- dec_valid  out  1  dec_instr/dec_pc hold a real instruction.
- dec_instr  out  32  oldest queued instruction, or NOP_WORD.
- dec_pc  out  32  PC of dec_instr, or 0 when not valid.
- bubble_cnt  out  16  saturating count of cycles in which decode was ready but the queue was empty.

## Operation
- Storage: DEPTH x {instr[31:0], pc[31:0]}. Read pointer, write pointer and count are registers. Count width is $clog2(DEPTH+1).
- Pointers increment modulo DEPTH: DEPTH-1 wraps to 0. No power-of-two masking.
- Full is count==DEPTH. Empty is count==0.
- fetch_stall equals full, decoded from count only. There is no combinational path from dec_stall or flush to fetch_stall.
- Push happens when fetch_valid && !full && !flush. The word is written at wr_ptr, and wr_ptr advances.
- Pop happens when dec_valid && !dec_stall && !flush. rd_ptr advances.
- Count update: count + push - pop. A simultaneous push and pop leaves count unchanged.
- When full, a push is rejected even if a pop occurs in the same cycle. Fetch re-presents the word because fetch_stall was high.
- Decode outputs are combinational from the head entry:
  - dec_valid = !empty && !flush.
  - dec_instr = dec_valid ? mem[rd_ptr].instr : NOP_WORD.
  - dec_pc = dec_valid ? mem[rd_ptr].pc : 0.
- Flush: on the next edge, count, rd_ptr and wr_ptr all become 0. A fetch_valid in the flush cycle is discarded because it is wrong-path. Storage contents are not cleared.
- Flush has priority over push, pop and dec_stall.
- bubble_cnt increments when empty && !dec_stall && !flush, and saturates at 16'hFFFF. Only rst clears it.

## Timing
- Reset (rst high at an edge) sets count=0, rd_ptr=0, wr_ptr=0 and bubble_cnt=0. Outputs after reset: dec_valid=0, dec_instr=NOP_WORD, dec_pc=0, fetch_stall=0, bubble_cnt=0.
- Reset asserted mid-operation behaves identically to reset and wins over flush, push and pop.
- Latency: a word pushed at edge N is visible on dec_* in cycle N+1. There is no same-cycle bypass, even when the queue is empty.
- Throughput: with dec_stall held low and fetch_valid continuous, one instruction per cycle passes through, and count stays at 1.
- dec_stall held with fetch_valid continuous: count rises by 1 per cycle until it reaches DEPTH. fetch_stall is high in the cycle after the DEPTH-th push.
- When dec_stall drops in a full cycle: one pop, no push. fetch_stall falls in the next cycle.
- The flush cycle shows dec_valid=0 and dec_instr=NOP_WORD combinationally. In the following cycle the queue is empty and fetch_stall=0.

## Test plan
- Reset then idle: hold rst 1 cycle, then fetch_valid=0 for 5 cycles. Required: dec_valid=0, dec_instr=32'h78000000, dec_pc=0, fetch_stall=0, and bubble_cnt=5.
- Streaming: push PCs 0x0600_2000, 0x0600_2004, 0x0600_2008 on consecutive cycles with dec_stall=0. Required: dec_pc shows each value one cycle after its push, in order; count never exceeds 1; fetch_stall stays 0.
- Fill and back-pressure (DEPTH=2): assert dec_stall and push A=0x11111111 and B=0x22222222. Required: fetch_stall=1 in the next cycle, and a third word C presented while full is not stored. Then release dec_stall. Required: dec_instr shows A, then B, then C after it is re-presented; no loss and no duplication.
- Wrap-around (DEPTH=3): stream 10 words with dec_stall toggling every 2 cycles. Required: output order equals input order across repeated pointer wraps.
- Flush while full: hold 2 entries and assert flush together with fetch_valid. Required: in the same cycle dec_instr=32'h78000000 and dec_valid=0. In the next cycle count=0 and fetch_stall=0, and the flush-cycle word never appears on dec_*.
- Reset mid-stream with flush and push active in the same cycle. Required: all state matches the reset values in the next cycle.
